// File: rtl/cpu_pkg.sv
// Shared CPU front-end encodings: fetch FSM states, redirect kinds, vector defaults.
package cpu_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } pc_state_e;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_BR   = 2'd1,
        RD_EXC  = 2'd2
    } redir_e;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch request bus between the PC generator (master) and instruction memory (slave).
interface pc_gen_if #(
    parameter int ADDR_W = 32
);
    logic              if_req_o;
    logic [ADDR_W-1:0] if_addr_o;
    logic              if_gnt_i;

    modport master (output if_req_o, output if_addr_o, input if_gnt_i);
    modport slave  (input if_req_o, input if_addr_o, output if_gnt_i);
endinterface

// File: rtl/pc_gen_redirect_hold.sv
// Holds one redirect that arrived while fetch was blocked; exceptions are sticky over branches.
module redirect_hold
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr_i,
    input  logic              cap_i,
    input  redir_e            live_kind_i,
    input  logic [ADDR_W-1:0] live_addr_i,
    output logic              pend_o,
    output redir_e            pend_kind_o,
    output logic [ADDR_W-1:0] pend_addr_o
);

    redir_e            kind_q;
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (!rstn || clr_i) begin
            kind_q <= RD_NONE;
            addr_q <= '0;
        end else if (cap_i) begin
            case (live_kind_i)
                RD_EXC: begin
                    kind_q <= RD_EXC;
                    addr_q <= live_addr_i;
                end
                // a branch must never displace a pending exception
                RD_BR: if (kind_q != RD_EXC) begin
                    kind_q <= RD_BR;
                    addr_q <= live_addr_i;
                end
                default: ;
            endcase
        end
    end

    assign pend_o      = (kind_q != RD_NONE);
    assign pend_kind_o = kind_q;
    assign pend_addr_o = addr_q;

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: one BOOT cycle, then sequential fetch with stall, branch and
// exception redirects; redirects seen while memory withholds grant are parked until it opens.
module pc_gen
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = RESET_VEC_DEF[ADDR_W-1:0],
    parameter logic [ADDR_W-1:0] EXC_VEC   = EXC_VEC_DEF[ADDR_W-1:0],
    parameter int                STEP      = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall_i,
    input  logic              br_flag_i,
    input  logic [ADDR_W-1:0] br_addr_i,
    input  logic              exc_flag_i,
    pc_gen_if.master          fif,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pend_o
);

    pc_state_e         state_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q;

    redir_e            live_kind;
    logic [ADDR_W-1:0] live_addr;
    logic              pend_vld;
    redir_e            pend_kind;
    logic [ADDR_W-1:0] pend_addr;
    logic              open;

    assign open = (state_q == ST_RUN) && fif.if_gnt_i;

    always_comb begin
        live_kind = RD_NONE;
        live_addr = br_addr_i;
        if (exc_flag_i) begin
            live_kind = RD_EXC;
            live_addr = EXC_VEC;
        end else if (br_flag_i) begin
            live_kind = RD_BR;
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (open) begin
            if (live_kind != RD_NONE) pc_d = live_addr;
            else if (pend_vld)        pc_d = pend_addr;
            else if (!stall_i)        pc_d = pc_q + ADDR_W'(STEP);
        end
    end

    // Pending state is dropped in BOOT and on any open cycle (whatever gets applied then wins).
    redirect_hold #(.ADDR_W(ADDR_W)) u_hold (
        .clk         (clk),
        .rstn        (rstn),
        .clr_i       ((state_q == ST_BOOT) || open),
        .cap_i       ((state_q == ST_RUN) && !fif.if_gnt_i),
        .live_kind_i (live_kind),
        .live_addr_i (live_addr),
        .pend_o      (pend_vld),
        .pend_kind_o (pend_kind),
        .pend_addr_o (pend_addr)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VEC;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q <= ST_RUN;
                    pc_q    <= RESET_VEC;
                    req_q   <= 1'b1;
                end
                default: begin
                    state_q <= ST_RUN;
                    pc_q    <= pc_d;
                    req_q   <= 1'b1;
                end
            endcase
        end
    end

    assign fif.if_req_o  = req_q;
    assign fif.if_addr_o = pc_q;
    assign pc_o          = pc_q;
    assign pend_o        = pend_vld;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a 32-bit instance for control flow, a 16-bit one for wrap-around.
module tb_pc_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_rstn, a_stall, a_br, a_exc;
    logic [31:0] a_br_addr, a_pc;
    logic        a_pend;
    pc_gen_if #(.ADDR_W(32)) a_if ();

    logic        b_rstn, b_stall, b_br, b_exc;
    logic [15:0] b_br_addr, b_pc;
    logic        b_pend;
    pc_gen_if #(.ADDR_W(16)) b_if ();

    pc_gen u_a (
        .clk(clk), .rstn(a_rstn), .stall_i(a_stall), .br_flag_i(a_br),
        .br_addr_i(a_br_addr), .exc_flag_i(a_exc), .fif(a_if), .pc_o(a_pc), .pend_o(a_pend)
    );

    pc_gen #(.ADDR_W(16), .STEP(4)) u_b (
        .clk(clk), .rstn(b_rstn), .stall_i(b_stall), .br_flag_i(b_br),
        .br_addr_i(b_br_addr), .exc_flag_i(b_exc), .fif(b_if), .pc_o(b_pc), .pend_o(b_pend)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [31:0] pc, input logic req, input logic pend);
        chk({tag, ".pc"},   a_pc, pc);
        chk({tag, ".addr"}, a_if.if_addr_o, pc);
        chk({tag, ".req"},  {31'd0, a_if.if_req_o}, {31'd0, req});
        chk({tag, ".pend"}, {31'd0, a_pend}, {31'd0, pend});
    endtask

    task automatic chk_b(input string tag, input logic [15:0] pc, input logic req, input logic pend);
        chk({tag, ".pc"},   {16'd0, b_pc}, {16'd0, pc});
        chk({tag, ".addr"}, {16'd0, b_if.if_addr_o}, {16'd0, pc});
        chk({tag, ".req"},  {31'd0, b_if.if_req_o}, {31'd0, req});
        chk({tag, ".pend"}, {31'd0, b_pend}, {31'd0, pend});
    endtask

    initial begin
        a_rstn = 0; a_stall = 0; a_br = 0; a_exc = 0; a_br_addr = '0; a_if.if_gnt_i = 1;
        b_rstn = 0; b_stall = 0; b_br = 0; b_exc = 0; b_br_addr = '0; b_if.if_gnt_i = 1;

        tick(); tick();
        chk_a("reset", 32'h3000, 0, 0);

        // BOOT cycle: a branch presented now must be ignored
        a_rstn = 1; a_br = 1; a_br_addr = 32'h9000;
        chk_a("boot", 32'h3000, 0, 0);
        tick(); a_br = 0;
        chk_a("run0", 32'h3000, 1, 0);
        tick(); chk_a("seq1", 32'h3004, 1, 0);
        tick(); chk_a("seq2", 32'h3008, 1, 0);
        tick(); chk_a("seq3", 32'h300C, 1, 0);
        tick(); chk_a("seq4", 32'h3010, 1, 0);

        a_stall = 1; a_br = 1; a_br_addr = 32'h3100;
        tick(); chk_a("stall_br", 32'h3100, 1, 0);
        a_br = 0;
        tick(); chk_a("stall_hold", 32'h3100, 1, 0);
        a_stall = 0;
        tick(); chk_a("unstall", 32'h3104, 1, 0);

        a_br = 1; a_br_addr = 32'h3020;
        tick(); chk_a("br3020", 32'h3020, 1, 0);

        a_if.if_gnt_i = 0; a_br_addr = 32'h3200;
        tick(); chk_a("pend_br", 32'h3020, 1, 1);
        a_br = 0;
        tick(); chk_a("pend_hold", 32'h3020, 1, 1);
        a_if.if_gnt_i = 1;
        tick(); chk_a("pend_apply", 32'h3200, 1, 0);

        a_if.if_gnt_i = 0; a_exc = 1;
        tick(); chk_a("pend_exc", 32'h3200, 1, 1);
        a_exc = 0; a_br = 1; a_br_addr = 32'h3300;
        tick(); chk_a("exc_sticky", 32'h3200, 1, 1);
        a_br = 0; a_if.if_gnt_i = 1;
        tick(); chk_a("exc_apply", 32'h4180, 1, 0);
        tick(); chk_a("after_exc", 32'h4184, 1, 0);

        a_if.if_gnt_i = 0; a_br = 1; a_br_addr = 32'h5000;
        tick(); a_br_addr = 32'h5100;
        tick(); a_br = 0; a_if.if_gnt_i = 1;
        tick(); chk_a("br_over_br", 32'h5100, 1, 0);

        a_if.if_gnt_i = 0; a_br = 1; a_br_addr = 32'h6000;
        tick(); a_br = 0; a_exc = 1;
        tick(); a_exc = 0; a_if.if_gnt_i = 1;
        tick(); chk_a("exc_over_br", 32'h4180, 1, 0);

        a_if.if_gnt_i = 0; a_br = 1; a_br_addr = 32'h7000;
        tick(); a_br_addr = 32'h7100; a_if.if_gnt_i = 1;
        tick(); chk_a("live_over_pend", 32'h7100, 1, 0);
        a_br = 0;
        tick(); chk_a("after_live", 32'h7104, 1, 0);

        a_if.if_gnt_i = 0; a_br = 1; a_br_addr = 32'h8000;
        tick(); chk_a("pend_pre_rst", 32'h7104, 1, 1);
        a_br = 0; a_rstn = 0;
        tick(); chk_a("rst_mid", 32'h3000, 0, 0);
        a_rstn = 1; a_if.if_gnt_i = 1;
        tick(); chk_a("reboot", 32'h3000, 1, 0);
        tick(); chk_a("reboot_seq", 32'h3004, 1, 0);

        b_rstn = 1;
        tick(); chk_b("b_boot", 16'h3000, 1, 0);
        b_br = 1; b_br_addr = 16'hFFFC;
        tick(); chk_b("b_top", 16'hFFFC, 1, 0);
        b_br = 0;
        tick(); chk_b("b_wrap", 16'h0000, 1, 0);
        tick(); chk_b("b_post", 16'h0004, 1, 0);
        b_if.if_gnt_i = 0; b_br = 1; b_br_addr = 16'h1234;
        tick(); chk_b("b_pend", 16'h0004, 1, 1);
        b_br = 0; b_rstn = 0;
        tick(); chk_b("b_rst", 16'h3000, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
